// File: rtl/tensor_stream_core_if.sv
// Byte-port bundle for tensor_stream_core: operand/result bytes, strobes and status.
// The core takes the slave view; the surrounding wrapper or bench drives the master view.
interface tensor_stream_core_if;
  logic [7:0] Datos_in;
  logic       Ena_write;
  logic       Ena_read;
  logic       enable_accu;
  logic       clear;
  logic [7:0] Datos_out;
  logic       Ena_out;
  logic       busy;

  modport master (
    output Datos_in, Ena_write, Ena_read, enable_accu, clear,
    input  Datos_out, Ena_out, busy
  );

  modport slave (
    input  Datos_in, Ena_write, Ena_read, enable_accu, clear,
    output Datos_out, Ena_out, busy
  );
endinterface

// File: rtl/tensor_stream_core.sv
// Byte-serial M_SIZE x M_SIZE matrix multiply/accumulate engine with one shared MAC.
// Define TFE_SATURATE_EN to clamp accumulator overflow; otherwise results wrap.
module tensor_stream_core #(
  parameter int M_SIZE    = 2,
  parameter int ACC_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  tensor_stream_core_if.slave bus
);

  localparam int N     = M_SIZE * M_SIZE;
  localparam int CW    = 16 + $clog2(M_SIZE);
  localparam int BYTES = ACC_WIDTH / 8;
  localparam int EW    = $clog2(N);
  localparam int IW    = $clog2(M_SIZE);
  localparam int BW    = $clog2(BYTES);
`ifdef TFE_SATURATE_EN
  localparam int SW    = ((ACC_WIDTH > CW) ? ACC_WIDTH : CW) + 1;
`endif

  localparam logic [EW-1:0] ELEM_LAST = EW'(N - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(M_SIZE - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nx_s;
  logic                   wr_q1_r, wr_q2_r, rd_q1_r, rd_q2_r;
  logic                   wr_evt_s, rd_evt_s, load_st_s, mac_last_s;
  logic [EW-1:0]          wr_ptr_r;
  logic [7:0]             a_r [N];
  logic [7:0]             b_r [N];
  logic [IW-1:0]          i_r, j_r, k_r;
  logic [EW-1:0]          a_idx_s, b_idx_s, c_idx_s;
  logic [15:0]            prod_s;
  logic [CW-1:0]          partial_r;
  logic [CW-1:0]          c_r [N];
  logic [ACC_WIDTH-1:0]   acc_r [N];
  logic [EW-1:0]          rd_elem_r;
  logic [BW-1:0]          rd_byte_r;
  logic [7:0]             datos_out_r;
  logic                   ena_out_r;
  logic                   busy_r;

  // Folds a product-sum into an accumulator element, clamping or wrapping on overflow.
  function automatic logic [ACC_WIDTH-1:0] fold_f(input logic [ACC_WIDTH-1:0] base,
                                                   input logic [CW-1:0]        c);
`ifdef TFE_SATURATE_EN
    logic [SW-1:0] sum;
    sum = SW'(base) + SW'(c);
    if (sum > SW'({ACC_WIDTH{1'b1}})) begin
      return {ACC_WIDTH{1'b1}};
    end else begin
      return sum[ACC_WIDTH-1:0];
    end
`else
    return base + ACC_WIDTH'(c);
`endif
  endfunction

  assign wr_evt_s   = wr_q1_r & ~wr_q2_r;
  assign rd_evt_s   = rd_q1_r & ~rd_q2_r;
  assign load_st_s  = (state_r == LOAD_A) || (state_r == LOAD_B);
  assign mac_last_s = (i_r == IDX_LAST) && (j_r == IDX_LAST) && (k_r == IDX_LAST);
  assign a_idx_s    = EW'(int'(i_r) * M_SIZE + int'(k_r));
  assign b_idx_s    = EW'(int'(k_r) * M_SIZE + int'(j_r));
  assign c_idx_s    = EW'(int'(i_r) * M_SIZE + int'(j_r));
  assign prod_s     = {8'd0, a_r[a_idx_s]} * {8'd0, b_r[b_idx_s]};

  // Two-stage strobe registers; a held strobe produces a single event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q1_r <= 1'b0;
      wr_q2_r <= 1'b0;
      rd_q1_r <= 1'b0;
      rd_q2_r <= 1'b0;
    end else begin
      wr_q1_r <= bus.Ena_write;
      wr_q2_r <= wr_q1_r;
      rd_q1_r <= bus.Ena_read;
      rd_q2_r <= rd_q1_r;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= LOAD_A;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Sequencer next state: clear always returns to LOAD_A.
  always_comb begin
    state_nx_s = state_r;
    if (bus.clear) begin
      state_nx_s = LOAD_A;
    end else begin
      case (state_r)
        LOAD_A:  state_nx_s = (wr_evt_s && (wr_ptr_r == ELEM_LAST)) ? LOAD_B : LOAD_A;
        LOAD_B:  state_nx_s = (wr_evt_s && (wr_ptr_r == ELEM_LAST)) ? COMPUTE : LOAD_B;
        COMPUTE: state_nx_s = mac_last_s ? UPDATE : COMPUTE;
        UPDATE:  state_nx_s = LOAD_A;
        default: state_nx_s = LOAD_A;
      endcase
    end
  end

  // Operand capture; A and B share one element pointer since they load back to back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {EW{1'b0}};
      for (int e = 0; e < N; e++) begin
        a_r[e] <= 8'd0;
        b_r[e] <= 8'd0;
      end
    end else if (bus.clear) begin
      wr_ptr_r <= {EW{1'b0}};
    end else if (wr_evt_s && load_st_s) begin
      if (state_r == LOAD_A) begin
        a_r[wr_ptr_r] <= bus.Datos_in;
      end else begin
        b_r[wr_ptr_r] <= bus.Datos_in;
      end
      wr_ptr_r <= (wr_ptr_r == ELEM_LAST) ? {EW{1'b0}} : wr_ptr_r + EW'(1);
    end
  end

  // Time-multiplexed MAC: k innermost, result element stored when k wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_r       <= {IW{1'b0}};
      j_r       <= {IW{1'b0}};
      k_r       <= {IW{1'b0}};
      partial_r <= {CW{1'b0}};
      for (int e = 0; e < N; e++) begin
        c_r[e] <= {CW{1'b0}};
      end
    end else if (bus.clear || (state_r != COMPUTE)) begin
      i_r       <= {IW{1'b0}};
      j_r       <= {IW{1'b0}};
      k_r       <= {IW{1'b0}};
      partial_r <= {CW{1'b0}};
    end else if (k_r == IDX_LAST) begin
      c_r[c_idx_s] <= partial_r + CW'(prod_s);
      partial_r    <= {CW{1'b0}};
      k_r          <= {IW{1'b0}};
      if (j_r == IDX_LAST) begin
        j_r <= {IW{1'b0}};
        i_r <= (i_r == IDX_LAST) ? {IW{1'b0}} : i_r + IW'(1);
      end else begin
        j_r <= j_r + IW'(1);
      end
    end else begin
      partial_r <= partial_r + CW'(prod_s);
      k_r       <= k_r + IW'(1);
    end
  end

  // Accumulator update, byte readout and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_elem_r   <= {EW{1'b0}};
      rd_byte_r   <= {BW{1'b0}};
      datos_out_r <= 8'd0;
      ena_out_r   <= 1'b0;
      busy_r      <= 1'b0;
      for (int e = 0; e < N; e++) begin
        acc_r[e] <= {ACC_WIDTH{1'b0}};
      end
    end else begin
      busy_r    <= (state_nx_s == COMPUTE) || (state_nx_s == UPDATE);
      ena_out_r <= 1'b0;
      if (bus.clear) begin
        rd_elem_r <= {EW{1'b0}};
        rd_byte_r <= {BW{1'b0}};
        for (int e = 0; e < N; e++) begin
          acc_r[e] <= {ACC_WIDTH{1'b0}};
        end
      end else if (state_r == UPDATE) begin
        rd_elem_r <= {EW{1'b0}};
        rd_byte_r <= {BW{1'b0}};
        for (int e = 0; e < N; e++) begin
          acc_r[e] <= fold_f(bus.enable_accu ? acc_r[e] : {ACC_WIDTH{1'b0}}, c_r[e]);
        end
      end else if (rd_evt_s && load_st_s) begin
        datos_out_r <= acc_r[rd_elem_r][{rd_byte_r, 3'b000} +: 8];
        ena_out_r   <= 1'b1;
        if (rd_byte_r == BYTE_LAST) begin
          rd_byte_r <= {BW{1'b0}};
          rd_elem_r <= (rd_elem_r == ELEM_LAST) ? {EW{1'b0}} : rd_elem_r + EW'(1);
        end else begin
          rd_byte_r <= rd_byte_r + BW'(1);
        end
      end
    end
  end

  assign bus.Datos_out = datos_out_r;
  assign bus.Ena_out   = ena_out_r;
  assign bus.busy      = busy_r;

endmodule

// File: doc/tensor_stream_core.md
# tensor_stream_core

Parametrised byte-serial matrix engine: receives two M_SIZE×M_SIZE unsigned 8-bit operand matrices over the byte port and multiplies them with a single time-multiplexed MAC. It adds the product into, or overwrites, a resident accumulator matrix and streams the accumulator back out byte by byte. It is the next-generation TPU top for the TinyTapeout wrapper, replacing the fixed 64-bit load/multiply/accumulate/readout chain with one configurable, sequenced block.

## Interface
- M_SIZE, 2, matrix dimension; legal 2..4.
- ACC_WIDTH, 16, accumulator element width in bits; multiple of 8, ≥ 16.
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- Datos_in  input  8  operand byte.
- Ena_write  input  1  write strobe; one rising edge = one byte.
- Ena_read  input  1  read strobe; one rising edge = one output byte.
- enable_accu  input  1  level; 1 = add product to accumulator, 0 = overwrite.
- clear  input  1  synchronous clear of accumulator and sequencer.
- Datos_out  output  8  output byte, held until next read.
- Ena_out  output  1  one-cycle pulse: new Datos_out valid.
- busy  output  1  high during COMPUTE and UPDATE.

## Operation
- Strobe conditioning:
  - Ena_write and Ena_read each pass through two registers (q1, q2).
  - edge = q1 & !q2.
  - A held-high strobe yields exactly one event.
- FSM states: LOAD_A → LOAD_B → COMPUTE → UPDATE → LOAD_A.
- LOAD_A / LOAD_B:
  - Each write event stores Datos_in row-major at the element pointer.
  - After M_SIZE² bytes the pointer returns to 0 and the state advances.
  - Write events in COMPUTE/UPDATE are dropped, not queued.
- COMPUTE:
  - One unsigned MAC per cycle, k innermost, i/j row-major.
  - C[i][j] = Σk A[i][k]·B[k][j], held at full width 16+clog2(M_SIZE).
  - Lasts M_SIZE³ cycles.
- UPDATE (1 cycle):
  - enable_accu is sampled in this cycle.
  - 1: ACC ← ACC + C. 0: ACC ← C.
  - Values beyond ACC_WIDTH are handled per Configuration.
  - Read pointer resets to 0.
- Readout:
  - Permitted in LOAD_A/LOAD_B only; read events in COMPUTE/UPDATE are ignored (no Ena_out).
  - ACC elements are sent row-major, each ACC_WIDTH/8 bytes, least-significant byte first.
  - After the last byte (M_SIZE²·ACC_WIDTH/8) the pointer wraps to 0.
- clear:
  - Zeroes ACC, both element pointers and the read pointer.
  - Forces LOAD_A and aborts any partial load or computation.
  - Wins over simultaneous write, read and UPDATE.
- Simultaneous write and read events in a load state are both serviced in the same cycle.
- A and B contents persist; only ACC is cleared by clear.

## Timing
- Reset values: Datos_out=0, Ena_out=0, busy=0, ACC=0, state LOAD_A, all pointers 0, strobe registers 0.
- Write capture:
  - Datos_in is captured at the second rising clk edge at which Ena_write is high.
  - Datos_in must be stable across both of those edges.
  - Ena_write must be low for ≥2 cycles between bytes.
- busy rises the cycle after the last B byte is captured and stays high M_SIZE³+1 cycles.
- ACC is valid and reads are accepted the cycle busy falls.
- Read response:
  - Datos_out updates and Ena_out pulses for one cycle at the second edge with Ena_read high.
  - Datos_out holds afterwards.
- Reset mid-operation returns immediately to reset values; no partial result is kept.

## Configuration
- TFE_SATURATE_EN defined: UPDATE clamps each element to 2^ACC_WIDTH−1 on overflow.
- TFE_SATURATE_EN undefined: results wrap modulo 2^ACC_WIDTH.

## Test plan
All scenarios use M_SIZE=2, ACC_WIDTH=16.
- Basic multiply: write A=1,2,3,4 and B=5,6,7,8 with enable_accu=0, then 8 reads -> 13 00 16 00 2B 00 32 00; busy high 9 cycles.
- Accumulate: repeat the same load with enable_accu=1, then 8 reads -> 26 00 2C 00 56 00 64 00; a 9th read -> 26 (wrap).
- Overflow: write A=B=all FF with enable_accu=0, then reads -> element 0 = FF FF with TFE_SATURATE_EN defined, 02 FC without.
- Clear mid-load: write 3 bytes of A, assert clear 1 cycle, then a full load of 1,2,3,4 / 5,6,7,8 -> 13 00 16 00 2B 00 32 00.
- Strobes while busy: pulse Ena_read and Ena_write during COMPUTE -> no Ena_out, no byte stored; the next load starts at element 0.
- Reset mid-COMPUTE: deassert rst for 1 cycle -> busy=0, Datos_out=0, first read returns 00.
